// File: rtl/gcbp_line_timing_gen.sv
// gcbp_line_timing_gen
//   Raster timing source for one video frame. Walks an internal (pix, line)
//   position one step per enabled pixel clock and registers the decodes of
//   that position onto the outputs, so every output lags i_enable by 1 clock.
//   Horizontal and vertical phases are tracked by two small FSMs
//   (ACT -> FP -> SYNC -> BP) that step on the last pixel/line of each phase.
//
// Ports
//   i_clk          pixel clock, rising edge
//   i_resetn       asynchronous active-low reset
//   i_enable       1 = emit one raster position this cycle
//   o_valid        registered i_enable; qualifies all other outputs
//   o_pix_cnt      pixel index in line, 0..H_TOTAL-1
//   o_line_cnt     line index in frame, 0..V_TOTAL-1
//   o_active       visible pixel on a visible line
//   o_hsync        active-low horizontal sync
//   o_vsync        active-low vertical sync
//   o_line_start   strobe on pixel 0 of every line
//   o_frame_start  strobe on pixel 0 of line 0
//
// Handshake: there is no back-pressure. A position is consumed only on a
//   cycle where i_enable is 1; the matching outputs appear on the next
//   cycle with o_valid = 1. With i_enable = 0 the position, counters and
//   sync levels hold and the strobes/valid drop to 0.
module gcbp_line_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_enable,
  output logic       o_valid,
  output logic [9:0] o_pix_cnt,
  output logic [9:0] o_line_cnt,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last position of each phase; the FSM leaves the phase after it.
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  logic [9:0] pix_q, line_q, pix_next, line_next;
  logic       pix_wrap, line_wrap;
  logic       act_d, hsync_n_d, vsync_n_d, line_start_d, frame_start_d;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      h_state <= HS_ACT;
      v_state <= VS_ACT;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
      pix_q   <= pix_next;
      line_q  <= line_next;
    end
  end

  always_comb begin
    pix_wrap  = (pix_q == H_LAST);
    line_wrap = (line_q == V_LAST);
    h_next    = h_state;
    v_next    = v_state;
    pix_next  = pix_q;
    line_next = line_q;

    if (i_enable) begin
      pix_next = pix_wrap ? '0 : pix_q + 10'd1;
      unique case (h_state)
        HS_ACT:  if (pix_q == H_ACT_END)  h_next = HS_FP;
        HS_FP:   if (pix_q == H_FP_END)   h_next = HS_SYNC;
        HS_SYNC: if (pix_q == H_SYNC_END) h_next = HS_BP;
        HS_BP:   if (pix_wrap)            h_next = HS_ACT;
        default:                          h_next = HS_ACT;
      endcase

      // Vertical state and line count move only on the line-wrap pixel,
      // so vsync and o_line_cnt change together on the next line's pixel 0.
      if (pix_wrap) begin
        line_next = line_wrap ? '0 : line_q + 10'd1;
        unique case (v_state)
          VS_ACT:  if (line_q == V_ACT_END)  v_next = VS_FP;
          VS_FP:   if (line_q == V_FP_END)   v_next = VS_SYNC;
          VS_SYNC: if (line_q == V_SYNC_END) v_next = VS_BP;
          VS_BP:   if (line_wrap)            v_next = VS_ACT;
          default:                           v_next = VS_ACT;
        endcase
      end
    end

    // Decodes of the current position, registered below.
    act_d         = (h_state == HS_ACT) && (v_state == VS_ACT);
    hsync_n_d     = (h_state != HS_SYNC);
    vsync_n_d     = (v_state != VS_SYNC);
    line_start_d  = (pix_q == '0);
    frame_start_d = (pix_q == '0) && (line_q == '0);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_valid       <= 1'b0;
      o_pix_cnt     <= '0;
      o_line_cnt    <= '0;
      o_active      <= 1'b0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_enable) begin
      o_valid       <= 1'b1;
      o_pix_cnt     <= pix_q;
      o_line_cnt    <= line_q;
      o_active      <= act_d;
      o_hsync       <= hsync_n_d;
      o_vsync       <= vsync_n_d;
      o_line_start  <= line_start_d;
      o_frame_start <= frame_start_d;
    end else begin
      // Counters and sync levels hold; qualifiers and strobes drop.
      o_valid       <= 1'b0;
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule
